// File: rtl/logarithm_pkg.sv
// Shared widths, constants and the ln(1+m) table generator for the logarithm pipeline.
package logarithm_pkg;
    localparam int Y_WIDTH_INT  = 4;
    localparam int Y_WIDTH_FRAC = 12;
    localparam int X_WIDTH_INT  = 4;
    localparam int X_WIDTH_FRAC = 12;
    localparam int SEG_BITS     = 6;
    localparam int GUARD        = 4;

    localparam int YW           = Y_WIDTH_INT + Y_WIDTH_FRAC;
    localparam int XW           = X_WIDTH_INT + X_WIDTH_FRAC;
    localparam int LOG_SEG_BITS = SEG_BITS;
    localparam int SEGS         = 1 << SEG_BITS;
    localparam int LNF          = X_WIDTH_FRAC + GUARD;
    localparam int R_BITS       = YW - 1 - SEG_BITS;
    localparam int P_W          = $clog2(YW);
    localparam int K_W          = P_W + 1;
    localparam int S_W          = X_WIDTH_INT + 2 + LNF;
    localparam int T_W          = S_W - GUARD;
    localparam int LOG_LATENCY  = 5;
    // round(ln(2) * 2^LNF)
    localparam int LOG_LN2      = 45426;

    // ln(1 + seg/2^SEG_BITS) in LNF fraction bits, via 2*atanh(seg/(2^(SEG_BITS+1)+seg)).
    // Only ever called with constant arguments, so it folds into table constants.
    function automatic logic [LNF-1:0] ln_q(input int seg);
        longint t;
        longint t2;
        longint term;
        longint acc;
        t    = (longint'(seg) <<< 28) / longint'((2 << SEG_BITS) + seg);
        t2   = (t * t) >>> 28;
        term = t;
        acc  = 0;
        for (int n = 0; n < 12; n++) begin
            acc  = acc + term / longint'(2 * n + 1);
            term = (term * t2) >>> 28;
        end
        return LNF'(((acc <<< 1) + (longint'(1) <<< (27 - LNF))) >>> (28 - LNF));
    endfunction
endpackage

// File: rtl/log_seg_rom.sv
// Registered segment ROM: seg -> {ln(1+seg/2^S), ln(1+(seg+1)/2^S) - ln(1+seg/2^S)}.
module log_seg_rom
    import logarithm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SEG_BITS-1:0] seg,
    output logic [LNF-1:0]      base,
    output logic [LNF-1:0]      slope
);
    logic [LNF-1:0] base_tab  [SEGS];
    logic [LNF-1:0] slope_tab [SEGS];

    for (genvar g = 0; g < SEGS; g++) begin : g_rom
        localparam logic [LNF-1:0] BASE_G  = ln_q(g);
        localparam logic [LNF-1:0] SLOPE_G = ln_q(g + 1) - ln_q(g);
        assign base_tab[g]  = BASE_G;
        assign slope_tab[g] = SLOPE_G;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base  <= '0;
            slope <= '0;
        end else begin
            base  <= base_tab[seg];
            slope <= slope_tab[seg];
        end
    end
endmodule

// File: rtl/logarithm.sv
// Five-stage pipelined x = ln(y): leading-one detect, normalise, ROM read,
// interpolate + k*ln2, sum/truncate/clamp.
module logarithm
    import logarithm_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          data_valid,
    input  logic [YW-1:0] y,
    output logic [XW-1:0] x,
    output logic          new_result,
    output logic          zero_in,
    output logic          saturated
);
    // Handshake: a sample is taken on every rising edge where data_valid=1; exactly
    // LOG_LATENCY cycles later new_result=1 for one cycle with x/zero_in/saturated.
    // There is no backpressure. On bubbles new_result=0 and the outputs hold.
    localparam logic signed [S_W-1:0] LN2_S = S_W'(LOG_LN2);
    localparam logic signed [T_W-1:0] X_LO  = T_W'(-(2 ** (XW - 1)));
    localparam logic signed [T_W-1:0] X_HI  = T_W'(2 ** (XW - 1) - 1);
    localparam logic [XW-1:0]         X_MIN = {1'b1, {(XW - 1){1'b0}}};
    localparam logic [XW-1:0]         X_MAX = {1'b0, {(XW - 1){1'b1}}};

    logic                  s1_v, s1_zero;
    logic [YW-1:0]         s1_y;
    logic [P_W-1:0]        s1_p;
    logic                  s2_v, s2_zero;
    logic [SEG_BITS-1:0]   s2_seg;
    logic [R_BITS-1:0]     s2_r;
    logic [K_W-1:0]        s2_k;
    logic                  s3_v, s3_zero;
    logic [R_BITS-1:0]     s3_r;
    logic [K_W-1:0]        s3_k;
    logic                  s4_v, s4_zero;
    logic [LNF-1:0]        s4_lnm;
    logic signed [S_W-1:0] s4_kl;

    logic [P_W-1:0]        lod_p;
    logic [YW-2:0]         frac_c;
    logic [K_W-1:0]        k_c;
    logic [LNF-1:0]        base_q, slope_q;
    logic [LNF-1:0]        interp_c, lnm_c;
    logic signed [S_W-1:0] kl_c, sum_c;
    logic signed [T_W-1:0] st_c;
    logic [XW-1:0]         x_c;
    logic                  sat_c;

    always_comb begin
        lod_p = '0;
        for (int i = 0; i < YW; i++) begin
            if (y[i]) lod_p = P_W'(i);
        end
    end

    // The implicit leading one falls off the top; the rest is the fraction of m.
    assign frac_c = (YW - 1)'(s1_y << (P_W'(YW - 1) - s1_p));
    assign k_c    = K_W'({1'b0, s1_p}) - K_W'(Y_WIDTH_FRAC);

    log_seg_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .seg   (s2_seg),
        .base  (base_q),
        .slope (slope_q)
    );

    assign interp_c = LNF'(({{LNF{1'b0}}, s3_r} * {{R_BITS{1'b0}}, slope_q}) >> R_BITS);
    assign lnm_c    = base_q + interp_c;
    assign kl_c     = $signed({{(S_W - K_W){s3_k[K_W-1]}}, s3_k}) * LN2_S;
    assign sum_c    = s4_kl + $signed({{(S_W - LNF){1'b0}}, s4_lnm});
    assign st_c     = T_W'(sum_c >>> GUARD);

    always_comb begin
        x_c   = st_c[XW-1:0];
        sat_c = 1'b0;
        if (st_c < X_LO) begin
            x_c   = X_MIN;
            sat_c = 1'b1;
        end else if (st_c > X_HI) begin
            x_c   = X_MAX;
            sat_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v <= 1'b0; s1_zero <= 1'b0; s1_y <= '0; s1_p <= '0;
            s2_v <= 1'b0; s2_zero <= 1'b0; s2_seg <= '0; s2_r <= '0; s2_k <= '0;
            s3_v <= 1'b0; s3_zero <= 1'b0; s3_r <= '0; s3_k <= '0;
            s4_v <= 1'b0; s4_zero <= 1'b0; s4_lnm <= '0; s4_kl <= '0;
            x <= '0; new_result <= 1'b0; zero_in <= 1'b0; saturated <= 1'b0;
        end else begin
            s1_v    <= data_valid;
            s1_zero <= (y == '0);
            s1_y    <= y;
            s1_p    <= lod_p;

            s2_v    <= s1_v;
            s2_zero <= s1_zero;
            s2_seg  <= frac_c[YW-2 -: SEG_BITS];
            s2_r    <= frac_c[R_BITS-1:0];
            s2_k    <= k_c;

            s3_v    <= s2_v;
            s3_zero <= s2_zero;
            s3_r    <= s2_r;
            s3_k    <= s2_k;

            s4_v    <= s3_v;
            s4_zero <= s3_zero;
            s4_lnm  <= lnm_c;
            s4_kl   <= kl_c;

            new_result <= s4_v;
            if (s4_v) begin
                x         <= s4_zero ? X_MIN : x_c;
                zero_in   <= s4_zero;
                saturated <= s4_zero ? 1'b0 : sat_c;
            end
        end
    end
endmodule

// File: tb/tb_logarithm.sv
// Bench for logarithm: directed corner values, valid patterns, random stream and
// mid-stream reset, checked against a real-valued ln() reference with a 2 LSB tolerance.
module tb_logarithm;
    import logarithm_pkg::*;

    logic          clk;
    logic          reset;
    logic          data_valid;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
    logic          new_result;
    logic          zero_in;
    logic          saturated;

    int            compared;
    int            mismatched;
    logic [YW:0]   exp_q[$];
    logic [XW-1:0] prev_x;

    logarithm dut (
        .clk        (clk),
        .reset      (reset),
        .data_valid (data_valid),
        .y          (y),
        .x          (x),
        .new_result (new_result),
        .zero_in    (zero_in),
        .saturated  (saturated)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [YW-1:0] rand_y();
        return YW'($urandom_range(0, 65535) >> $urandom_range(0, 15));
    endfunction

    task automatic check_eq(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // scoreboard: front of exp_q is the sample whose result is due this cycle
    task automatic check_out();
        logic [YW:0]   e;
        logic [YW-1:0] ey;
        real           l;
        int            r;
        int            d;
        if (exp_q.size() == LOG_LATENCY) e = exp_q.pop_front();
        else e = '0;
        ey = e[YW-1:0];
        if (!e[YW]) begin
            check_eq("bubble_new_result", XW'(new_result), '0);
            check_eq("bubble_hold_x", x, prev_x);
        end else begin
            check_eq("new_result", XW'(new_result), XW'(1));
            if (ey == '0) begin
                check_eq("zero_x", x, 16'h8000);
                check_eq("zero_in", XW'(zero_in), XW'(1));
                check_eq("zero_sat", XW'(saturated), '0);
            end else begin
                l = $ln(real'(ey) / 4096.0) * 4096.0;
                if (l < -32768.0) begin
                    check_eq("sat_x", x, 16'h8000);
                    check_eq("sat_flag", XW'(saturated), XW'(1));
                    check_eq("sat_zero_in", XW'(zero_in), '0);
                end else begin
                    r = (l < 0.0) ? $rtoi(l - 0.5) : $rtoi(l + 0.5);
                    d = int'($signed(x)) - r;
                    compared++;
                    assert (d >= -2 && d <= 2) else begin
                        mismatched++;
                        $error("FAIL ln_tol y=%h: observed %0d expected %0d +/-2", ey, int'($signed(x)), r);
                    end
                    check_eq("flags_clear", XW'({zero_in, saturated}), '0);
                end
            end
        end
        prev_x = x;
    endtask

    // driver: check this cycle's outputs, then present the next input
    task automatic step(input logic v, input logic [YW-1:0] yv);
        @(negedge clk);
        check_out();
        data_valid = v;
        y          = yv;
        exp_q.push_back({v, yv});
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("rst_x", x, '0);
        check_eq("rst_new_result", XW'(new_result), '0);
        check_eq("rst_flags", XW'({zero_in, saturated}), '0);
        data_valid = 1'b1;
        y          = 16'h1000;
        #1 reset = 1'b1;
        exp_q.delete();
        exp_q.push_back({1'b1, y});
        prev_x = '0;
    endtask

    initial begin
        logic pat [6];
        compared   = 0;
        mismatched = 0;
        prev_x     = '0;
        reset      = 1'b0;
        data_valid = 1'b0;
        y          = '0;
        repeat (2) @(negedge clk);
        check_eq("init_x", x, '0);
        check_eq("init_new_result", XW'(new_result), '0);
        check_eq("init_flags", XW'({zero_in, saturated}), '0);
        reset = 1'b1;

        step(1'b1, 16'h1000);
        step(1'b1, 16'h2B7E);
        step(1'b1, 16'h0800);
        step(1'b1, 16'h0000);
        step(1'b1, 16'h0001);
        step(1'b1, 16'hFFFF);
        step(1'b1, 16'h0002);
        step(1'b1, 16'h0FFF);
        repeat (6) step(1'b0, rand_y());

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 6; i++) step(pat[i], rand_y());
        end

        for (int i = 0; i < 1000; i++) step(1'b1, rand_y());
        repeat (6) step(1'b0, rand_y());

        repeat (4) step(1'b1, rand_y());
        reset_pulse();
        repeat (4) step(1'b0, rand_y());
        repeat (8) step(1'b1, rand_y());
        repeat (6) step(1'b0, rand_y());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
